// File: rtl/spi_frame_master.sv
// Host-side SPI master that streams one framebuffer frame row by row to the display controller,
// then sends the load command so the controller swaps buffers.
module spi_frame_master #(
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8,
    parameter int clkdiv   = 2,
    parameter int gap      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       ren,
    output logic [$clog2(rows)-1:0]    rrow,
    output logic [$clog2(columns)-1:0] rcol,
    input  logic [3*bitwidth-1:0]      rdata,
    output logic                       ss,
    output logic                       sclk,
    output logic                       mosi
);

    localparam int unsigned RW = $clog2(rows);
    localparam int unsigned CW = $clog2(columns);
    localparam int unsigned PW = $clog2(2 * clkdiv);
    localparam int unsigned BW = $clog2(3 * columns + 1);
    localparam int unsigned GW = (gap > 1) ? $clog2(gap) : 1;

    localparam logic [PW-1:0] PH_LAST   = PW'(2 * clkdiv - 1);
    localparam logic [PW-1:0] PH_HIGH   = PW'(clkdiv);
    localparam logic [BW-1:0] BYTE_LAST = BW'(3 * columns);
    localparam logic [GW-1:0] GAP_LAST  = GW'(gap - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(rows - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(columns - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_XFER,
        S_ROW_GAP,
        S_LOAD_XFER,
        S_LOAD_GAP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]         phase;
    logic [2:0]            bitn;
    logic [BW-1:0]         byten;
    logic [1:0]            ch;
    logic                  tail;
    logic [GW-1:0]         gcnt;
    logic [7:0]            sh;
    logic [3*bitwidth-1:0] hold;
    logic                  cap;
    logic [RW-1:0]         cur_row;
    logic [RW-1:0]         nrow;

    logic xfer, bit_end, last_byte, gap_end, start_row, start_load;

    assign xfer      = (state == S_ROW_XFER) || (state == S_LOAD_XFER);
    assign bit_end   = xfer && !tail && (phase == PH_LAST);
    assign last_byte = (state == S_LOAD_XFER) || (byten == BYTE_LAST);
    assign gap_end   = gcnt == GAP_LAST;
    assign nrow      = (state == S_IDLE) ? '0 : cur_row + 1'b1;

    assign start_row  = (state_nxt == S_ROW_XFER) && (state != S_ROW_XFER);
    assign start_load = (state_nxt == S_LOAD_XFER) && (state != S_LOAD_XFER);

    // The trailing ss-high cycle forces sclk/mosi low before ss drops.
    assign ss   = xfer;
    assign sclk = xfer && !tail && (phase >= PH_HIGH);
    assign mosi = xfer && !tail && sh[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_ROW_XFER;
            end
            S_ROW_XFER: begin
                if (tail) state_nxt = S_ROW_GAP;
            end
            S_ROW_GAP: begin
                if (gap_end) state_nxt = (cur_row == ROW_LAST) ? S_LOAD_XFER : S_ROW_XFER;
            end
            S_LOAD_XFER: begin
                if (tail) state_nxt = S_LOAD_GAP;
            end
            S_LOAD_GAP: begin
                if (gap_end) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   <= '0;
            bitn    <= '0;
            byten   <= '0;
            ch      <= '0;
            tail    <= 1'b0;
            gcnt    <= '0;
            sh      <= '0;
            hold    <= '0;
            cap     <= 1'b0;
            cur_row <= '0;
            ren     <= 1'b0;
            rrow    <= '0;
            rcol    <= '0;
        end else begin
            ren <= 1'b0;
            cap <= ren;
            if (cap) hold <= rdata;

            if ((state == S_ROW_GAP) || (state == S_LOAD_GAP)) begin
                gcnt <= gcnt + 1'b1;
            end else begin
                gcnt <= '0;
            end

            if (start_row || start_load) begin
                phase <= '0;
                bitn  <= '0;
                byten <= '0;
                ch    <= '0;
                tail  <= 1'b0;
                if (start_row) begin
                    cur_row <= nrow;
                    sh      <= {4'hF, 4'(nrow)};
                    ren     <= 1'b1;
                    rrow    <= nrow;
                    rcol    <= '0;
                end else begin
                    sh <= 8'h10;
                end
            end else if (xfer && !tail) begin
                if (bit_end) begin
                    phase <= '0;
                    if (bitn != 3'd7) begin
                        bitn <= bitn + 3'd1;
                        sh   <= {sh[6:0], 1'b0};
                    end else begin
                        bitn <= '0;
                        if (last_byte) begin
                            tail <= 1'b1;
                        end else begin
                            byten <= byten + 1'b1;
                            // Loading the B byte is the moment to prefetch the next pixel.
                            case (ch)
                                2'd0: begin
                                    sh <= hold[2*bitwidth +: 8];
                                    ch <= 2'd1;
                                end
                                2'd1: begin
                                    sh <= hold[bitwidth +: 8];
                                    ch <= 2'd2;
                                end
                                default: begin
                                    sh <= hold[0 +: 8];
                                    ch <= 2'd0;
                                    if (rcol != COL_LAST) begin
                                        ren  <= 1'b1;
                                        rcol <= rcol + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: expected SPI bytes, ss lengths and read addresses are queued
// when a frame is started and checked by a serial monitor as the DUT produces them.
module tb_spi_frame_master;

    localparam int ROWS      = 8;
    localparam int COLS      = 32;
    localparam int CLKDIV    = 2;
    localparam int GAP       = 4;
    localparam int ROW_LEN   = 3105;
    localparam int LOAD_LEN  = 33;
    localparam int FRAME_LEN = 24909;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, ren;
    logic [2:0]  rrow;
    logic [4:0]  rcol;
    logic [23:0] rdata = '0;
    logic        ss, sclk, mosi;

    spi_frame_master #(
        .rows    (ROWS),
        .columns (COLS),
        .bitwidth(8),
        .clkdiv  (CLKDIV),
        .gap     (GAP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .ren  (ren),
        .rrow (rrow),
        .rcol (rcol),
        .rdata(rdata),
        .ss   (ss),
        .sclk (sclk),
        .mosi (mosi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered framebuffer: valid data only in the cycle after ren, noise otherwise.
    always @(posedge clk) begin
        if (ren) rdata <= {8'(rrow), 8'hed, 8'(rcol)};
        else     rdata <= 24'($urandom);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] byte_q[$];
    logic [7:0] addr_q[$];
    int         len_q[$];

    logic       prev_ss = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic [7:0] shreg = '0;
    logic [7:0] exp_b;
    int         exp_l;
    int         nbits = 0, lo_run = 0, hi_run = 0;
    int         rise_cyc = 0, fall_cyc = 0, t_rise = 0;
    int         done_cnt = 0, phase_err = 0, mosi_err = 0;
    bit         first_pending = 0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_ss   = 1'b0;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
            nbits     = 0;
            lo_run    = 0;
            hi_run    = 0;
        end else begin
            if (ren) begin
                exp_b = (addr_q.size() > 0) ? addr_q.pop_front() : 8'hxx;
                chk("ren_addr", {rrow, rcol}, exp_b);
            end
            if (ss && !prev_ss) begin
                if (first_pending) begin
                    t_rise        = cyc;
                    first_pending = 0;
                end else begin
                    chk("ss_gap", cyc - fall_cyc, GAP);
                end
                rise_cyc = cyc;
                nbits    = 0;
                lo_run   = 0;
                hi_run   = 0;
            end
            if (!ss && prev_ss) begin
                fall_cyc = cyc;
                exp_l    = (len_q.size() > 0) ? len_q.pop_front() : -1;
                chk("ss_high", cyc - rise_cyc, exp_l);
                chk("bit_align", nbits % 8, 0);
            end
            if (ss) begin
                if (sclk) begin
                    if (!prev_sclk) begin
                        if (lo_run != CLKDIV) phase_err++;
                        shreg = {shreg[6:0], mosi};
                        nbits++;
                        if (nbits % 8 == 0) begin
                            exp_b = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hxx;
                            chk("spi_byte", shreg, exp_b);
                        end
                    end else if (mosi !== prev_mosi) begin
                        mosi_err++;
                    end
                    lo_run = 0;
                    hi_run++;
                end else begin
                    if (prev_sclk && hi_run != CLKDIV) phase_err++;
                    hi_run = 0;
                    lo_run++;
                end
            end else if (sclk) begin
                phase_err++;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 0);
                if (!first_pending) chk("frame_len", cyc - t_rise, FRAME_LEN);
            end
            prev_ss   = ss;
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
    end

    task automatic push_frame();
        for (int r = 0; r < ROWS; r++) begin
            len_q.push_back(ROW_LEN);
            byte_q.push_back(8'hF0 | 8'(r));
            for (int c = 0; c < COLS; c++) begin
                addr_q.push_back({3'(r), 5'(c)});
                byte_q.push_back(8'(r));
                byte_q.push_back(8'hed);
                byte_q.push_back(8'(c));
            end
        end
        len_q.push_back(LOAD_LEN);
        byte_q.push_back(8'h10);
        first_pending = 1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_bytes_left"}, byte_q.size(), 0);
        chk({tag, "_ren_left"}, addr_q.size(), 0);
        chk({tag, "_len_left"}, len_q.size(), 0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", ss, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ren", ren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rrow", rrow, 0);
        chk("rst_rcol", rcol, 0);
        @(negedge clk) rst = 1'b1;

        // Abort a frame part way through row 0.
        push_frame();
        pulse_start();
        chk("abort_busy_before", busy, 1);
        repeat (1000) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_ss", ss, 0);
        chk("abort_sclk", sclk, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_ren", ren, 0);
        chk("abort_busy", busy, 0);
        byte_q.delete();
        addr_q.delete();
        len_q.delete();
        first_pending = 0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_ss", ss, 0);

        // Full frame with three ignored starts: one mid-row, one in a row gap, one during load.
        push_frame();
        pulse_start();
        chk("frame_a_ss", ss, 1);
        repeat (200) @(posedge clk);
        pulse_start();
        repeat (2903) @(posedge clk);
        pulse_start();
        repeat (21772) @(posedge clk);
        pulse_start();
        wait_done();
        #1;
        chk("frame_a_done_cnt", done_cnt, 1);
        chk_drained("frame_a");

        // Restart in the cycle right after done.
        push_frame();
        pulse_start();
        chk("restart_ss", ss, 1);
        chk("restart_busy", busy, 1);
        wait_done();
        #1;
        chk("frame_b_done_cnt", done_cnt, 2);
        chk_drained("frame_b");
        repeat (20) @(posedge clk);
        #1;
        chk("final_done_cnt", done_cnt, 2);
        chk("final_ss", ss, 0);
        chk("mosi_stable", mosi_err, 0);
        chk("sclk_phase", phase_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
